snes_joypad_port: RTL and testbench



---
 rtl/snes_joypad_port_if.sv | 35 +++
 rtl/snes_joypad_port.sv | 102 ++++++++++
 tb/tb_snes_joypad_port.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/snes_joypad_port_if.sv
// Pad-side and console-side signals of one SNES controller port.
interface snes_joypad_port_if;
    logic [11:0] pad_btn;
    logic        pad_valid;
    logic [11:0] turbo_en;
    logic        vblank;
    logic        joy_strb;
    logic        joy_clk;
    logic [1:0]  joy_di;
    logic        pad_stale;

    // Port block side
    modport slave (
        input  pad_btn,
        input  pad_valid,
        input  turbo_en,
        input  vblank,
        input  joy_strb,
        input  joy_clk,
        output joy_di,
        output pad_stale
    );

    // Pad source / console side
    modport master (
        output pad_btn,
        output pad_valid,
        output turbo_en,
        output vblank,
        output joy_strb,
        output joy_clk,
        input  joy_di,
        input  pad_stale
    );
endinterface

// File: rtl/snes_joypad_port.sv
// SNES controller port: holds the latest pad state, applies turbo and a
// staleness timeout, and serialises a 16-bit word to the console latch/clock.
module snes_joypad_port #(
    parameter int unsigned TIMEOUT_CYCLES = 2147483,
    parameter int unsigned TURBO_HALF     = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    snes_joypad_port_if.slave  pad
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1) > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TRB_W = TURBO_HALF > 1 ? $clog2(TURBO_HALF) : 1;
    localparam int unsigned BTN_W = 12;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W = 5;

    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TRB_W-1:0] TRB_LAST = TRB_W'(TURBO_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);

    logic [BTN_W-1:0]  live;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              stale_q;
    logic              vblank_q;
    logic [TRB_W-1:0]  turbo_cnt;
    logic              turbo_phase;
    logic              jclk_q;
    logic              jclk_rise_q;
    logic [WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;

    logic [BTN_W-1:0]  eff_c;
    logic [WORD_W-1:0] port_word_c;

    // Capture pad samples and age them; a stale pad reads as all released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live    <= '0;
            tmo_cnt <= TMO_MAX;
            stale_q <= 1'b1;
        end else if (pad.pad_valid) begin
            live    <= pad.pad_btn;
            tmo_cnt <= '0;
            stale_q <= (TMO_MAX == TMO_W'(0));
        end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            stale_q <= ((tmo_cnt + TMO_W'(1)) == TMO_MAX);
        end
    end

    // Count frames on vblank rising edges and flip the turbo phase on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q    <= 1'b0;
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else begin
            vblank_q <= pad.vblank;
            if (pad.vblank && !vblank_q) begin
                if (turbo_cnt == TRB_LAST) begin
                    turbo_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    turbo_cnt <= turbo_cnt + TRB_W'(1);
                end
            end
        end
    end

    // Effective buttons and the raw-level port word (ID nibble reads released).
    always_comb begin
        eff_c       = (stale_q ? '0 : live) & ~(pad.turbo_en & {BTN_W{turbo_phase}});
        port_word_c = {4'hF, ~eff_c};
    end

    // Latch on strobe, shift on a registered joy_clk rise; strobe always wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jclk_q      <= 1'b0;
            jclk_rise_q <= 1'b0;
            shift_reg   <= '1;
            bit_cnt     <= CNT_FULL;
        end else begin
            jclk_q      <= pad.joy_clk;
            jclk_rise_q <= pad.joy_clk & ~jclk_q & ~pad.joy_strb;
            if (pad.joy_strb) begin
                shift_reg <= port_word_c;
                bit_cnt   <= '0;
            end else if (jclk_rise_q) begin
                shift_reg <= {1'b0, shift_reg[WORD_W-1:1]};
                if (bit_cnt != CNT_FULL) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign pad.joy_di    = {1'b1, shift_reg[0]};
    assign pad.pad_stale = stale_q;

endmodule

// File: tb/tb_snes_joypad_port.sv
// Directed bench for snes_joypad_port with a short timeout and 3-frame turbo.
module tb_snes_joypad_port;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fails;

    snes_joypad_port_if bus ();

    snes_joypad_port #(
        .TIMEOUT_CYCLES (100),
        .TURBO_HALF     (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pad     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pad_write(input logic [11:0] v);
        bus.pad_btn   = v;
        bus.pad_valid = 1'b1;
        tick(1);
        bus.pad_valid = 1'b0;
    endtask

    task automatic strobe();
        bus.joy_strb = 1'b1;
        tick(1);
        bus.joy_strb = 1'b0;
        tick(1);
    endtask

    task automatic pulse();
        bus.joy_clk = 1'b1;
        tick(2);
        bus.joy_clk = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [6:0] turbo_exp;
        n_checks      = 0;
        n_fails       = 0;
        reset_n       = 1'b0;
        bus.pad_btn   = '0;
        bus.pad_valid = 1'b0;
        bus.turbo_en  = '0;
        bus.vblank    = 1'b0;
        bus.joy_strb  = 1'b0;
        bus.joy_clk   = 1'b0;
        tick(2);

        // Reset state
        check("rst_joy_di", bus.joy_di, 2'b11);
        check("rst_stale", {1'b0, bus.pad_stale}, 2'b01);
        reset_n = 1'b1;
        tick(1);
        strobe();
        check("stale_word_bit0", bus.joy_di, 2'b11);

        // B pressed: word FFFE, then zeros after 16 shifts
        pad_write(12'h001);
        check("stale_clear", {1'b0, bus.pad_stale}, 2'b00);
        strobe();
        check("b_bit0", bus.joy_di, 2'b10);
        bus.joy_clk = 1'b1;
        tick(1);
        check("latency_1cyc", bus.joy_di, 2'b10);
        tick(1);
        check("latency_2cyc", bus.joy_di, 2'b11);
        bus.joy_clk = 1'b0;
        tick(1);
        for (int i = 2; i <= 20; i++) begin
            pulse();
            check($sformatf("b_seq_%0d", i), bus.joy_di, (i < 16) ? 2'b11 : 2'b10);
        end

        // All pressed, pad update mid-read must not disturb the shift register
        pad_write(12'hFFF);
        strobe();
        check("all_bit0", bus.joy_di, 2'b10);
        for (int i = 1; i <= 3; i++) begin
            pulse();
            check($sformatf("all_pre_%0d", i), bus.joy_di, 2'b10);
        end
        pad_write(12'h000);
        for (int i = 4; i <= 12; i++) begin
            pulse();
            check($sformatf("all_post_%0d", i), bus.joy_di, (i < 12) ? 2'b10 : 2'b11);
        end
        strobe();
        check("none_bit0", bus.joy_di, 2'b11);
        for (int i = 1; i <= 11; i++) begin
            pulse();
            check($sformatf("none_bit_%0d", i), bus.joy_di, 2'b11);
        end

        // pad_valid together with a latch: latch sees the old value
        bus.pad_btn   = 12'h001;
        bus.pad_valid = 1'b1;
        bus.joy_strb  = 1'b1;
        tick(1);
        bus.pad_valid = 1'b0;
        bus.joy_strb  = 1'b0;
        tick(1);
        check("coinc_old_live", bus.joy_di, 2'b11);
        strobe();
        check("coinc_new_live", bus.joy_di, 2'b10);

        // joy_clk rise in the same cycle as strobe: no shift
        bus.joy_strb = 1'b1;
        bus.joy_clk  = 1'b1;
        tick(1);
        bus.joy_strb = 1'b0;
        tick(2);
        check("strb_clk_noshift", bus.joy_di, 2'b10);
        bus.joy_clk = 1'b0;
        tick(1);
        pulse();
        check("strb_clk_bit1", bus.joy_di, 2'b11);

        // Timeout after 100 idle cycles
        pad_write(12'h0FF);
        check("tmo_fresh", {1'b0, bus.pad_stale}, 2'b00);
        tick(99);
        check("tmo_99", {1'b0, bus.pad_stale}, 2'b00);
        tick(1);
        check("tmo_100", {1'b0, bus.pad_stale}, 2'b01);
        strobe();
        check("tmo_bit0", bus.joy_di, 2'b11);
        for (int i = 1; i <= 15; i++) begin
            pulse();
            check($sformatf("tmo_bit_%0d", i), bus.joy_di, 2'b11);
        end

        // Turbo on B, one latch per frame
        bus.turbo_en = 12'h001;
        turbo_exp    = 7'b0111000;
        for (int f = 0; f < 7; f++) begin
            pad_write(12'h001);
            strobe();
            check($sformatf("turbo_f%0d", f), bus.joy_di, {1'b1, turbo_exp[f]});
            bus.vblank = 1'b1;
            tick(1);
            bus.vblank = 1'b0;
            tick(1);
        end
        bus.turbo_en = 12'h000;

        // Reset in the middle of a read
        pad_write(12'hFFF);
        strobe();
        for (int i = 1; i <= 5; i++) pulse();
        check("mid_read_bit5", bus.joy_di, 2'b10);
        reset_n = 1'b0;
        #1;
        check("rst_async", bus.joy_di, 2'b11);
        tick(2);
        check("rst_held", bus.joy_di, 2'b11);
        check("rst_stale_again", {1'b0, bus.pad_stale}, 2'b01);
        reset_n = 1'b1;
        tick(1);
        check("post_rst", bus.joy_di, 2'b11);
        pulse();
        check("post_rst_pulse", bus.joy_di, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
